// File: rtl/branch_resolve_predict.sv
// Purpose : condition-flag file with bypass, 2-bit counter prediction table, execute-stage branch resolution.
// Latency : f_pred_taken is combinational; res_*/mispredict/redirect_pc/counters are valid one cycle after r_valid.
// Backpres: none; one resolution accepted per cycle, nothing ever stalls.
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   flag_we, zero_in/sign_in/carry_in   ALU flags, latched on flag_we and bypassed in the same cycle
//   f_pc -> f_pred_taken          fetch-side lookup (counter MSB of the indexed entry)
//   r_valid, r_opcode, r_pc, r_target, r_pred_taken   execute-stage instruction
//   res_valid, res_taken, mispredict, redirect_pc     registered resolution
//   br_cnt, mp_cnt                saturating resolved-branch / misprediction counters
module branch_resolve_predict #(
    parameter int PC_W    = 32,
    parameter int IDX_W   = 4,
    parameter int IDX_LSB = 2,
    parameter int PC_INC  = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flag_we,
    input  logic             zero_in,
    input  logic             sign_in,
    input  logic             carry_in,
    input  logic [PC_W-1:0]  f_pc,
    output logic             f_pred_taken,
    input  logic             r_valid,
    input  logic [5:0]       r_opcode,
    input  logic [PC_W-1:0]  r_pc,
    input  logic [PC_W-1:0]  r_target,
    input  logic             r_pred_taken,
    output logic             res_valid,
    output logic             res_taken,
    output logic             mispredict,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mp_cnt
);

    localparam int DEPTH = 1 << IDX_W;

    logic             zfl, sfl, cfl;
    logic [1:0]       pht [DEPTH];

    logic             z_eff, s_eff, c_eff;
    logic             is_br, is_cond, cond;
    logic             take;
    logic [IDX_W-1:0] f_idx, r_idx;

    // Only the index bits of the PCs feed the table; the rest is deliberately ignored.
    logic             pc_unused;
    assign pc_unused = ^{f_pc, r_pc};

    assign f_idx = f_pc[IDX_LSB +: IDX_W];
    assign r_idx = r_pc[IDX_LSB +: IDX_W];

    // Lookup reads registered table state, so a same-cycle update at this index is not yet visible.
    assign f_pred_taken = pht[f_idx][1];

    // Flags written this cycle are forwarded straight to the resolution logic.
    assign z_eff = flag_we ? zero_in  : zfl;
    assign s_eff = flag_we ? sign_in  : sfl;
    assign c_eff = flag_we ? carry_in : cfl;

    always_comb begin
        is_br   = 1'b1;
        is_cond = 1'b1;
        cond    = 1'b0;
        case (r_opcode)
            6'b101011, 6'b101000, 6'b100000: begin
                is_cond = 1'b0;
                cond    = 1'b1;
            end
            6'b110001: cond = z_eff;
            6'b110010: cond = ~z_eff;
            6'b110000: cond = s_eff;
            6'b101001: cond = c_eff;
            6'b101010: cond = ~c_eff;
            default: begin
                is_br   = 1'b0;
                is_cond = 1'b0;
            end
        endcase
    end

    assign take = r_valid & is_br;

    always_ff @(posedge clk) begin
        if (rst) begin
            zfl         <= 1'b0;
            sfl         <= 1'b0;
            cfl         <= 1'b0;
            res_valid   <= 1'b0;
            res_taken   <= 1'b0;
            mispredict  <= 1'b0;
            redirect_pc <= '0;
            br_cnt      <= '0;
            mp_cnt      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pht[i] <= 2'b01;
            end
        end else begin
            if (flag_we) begin
                zfl <= zero_in;
                sfl <= sign_in;
                cfl <= carry_in;
            end

            res_valid  <= take;
            res_taken  <= take & cond;
            mispredict <= take & (cond != r_pred_taken);

            if (take) begin
                redirect_pc <= cond ? r_target : r_pc + PC_W'(PC_INC);
                if (br_cnt != '1) begin
                    br_cnt <= br_cnt + CNT_W'(1);
                end
                if ((cond != r_pred_taken) && (mp_cnt != '1)) begin
                    mp_cnt <= mp_cnt + CNT_W'(1);
                end
            end

            // Unconditional branches never train the table.
            if (take && is_cond) begin
                if (cond && pht[r_idx] != 2'b11) begin
                    pht[r_idx] <= pht[r_idx] + 2'b01;
                end else if (!cond && pht[r_idx] != 2'b00) begin
                    pht[r_idx] <= pht[r_idx] - 2'b01;
                end
            end
        end
    end

endmodule
